// File: rtl/dmem_responder_pkg.sv
// Shared types, constants and the request error check for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int BE_W       = 4;

  // A request errors when it is not word aligned or its word index falls past the storage.
  function automatic logic addr_err(input logic [31:0] addr, input logic [31:0] depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store port between the CPU (master) and the data-memory responder (slave).
interface dmem_responder_if #(
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [31:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [3:0]        req_be;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_responder_array.sv
// Word storage with a synchronous byte-masked write port and a combinational read port.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (be[i]) begin
          mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Target end of the CPU load/store port: accepts one request, waits LATENCY cycles,
// commits the read or byte-masked write and holds the response until the CPU takes it.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic           clk,
  input  logic           rst,
  dmem_responder_if.slave bus
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] LAT_M1 = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

  state_t            state, state_next;
  logic [3:0]        count, count_next;
  logic              lat_we, lat_we_next;
  logic [31:0]       lat_addr, lat_addr_next;
  logic [DATA_W-1:0] lat_wdata, lat_wdata_next;
  logic [BE_W-1:0]   lat_be, lat_be_next;
  logic [DATA_W-1:0] rdata_q, rdata_next;
  logic              err_q, err_next;

  logic              commit;
  logic              c_we;
  logic [31:0]       c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic [BE_W-1:0]   c_be;
  logic              c_err;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  // With zero latency the commit happens on the accept edge, so use the live request there.
  assign c_we    = (state == IDLE) ? bus.req_we    : lat_we;
  assign c_addr  = (state == IDLE) ? bus.req_addr  : lat_addr;
  assign c_wdata = (state == IDLE) ? bus.req_wdata : lat_wdata;
  assign c_be    = (state == IDLE) ? bus.req_be    : lat_be;
  assign c_err   = addr_err(c_addr, 32'(DEPTH_WORDS));
  assign mem_we  = commit && c_we && !c_err && rst;

  dmem_array #(
    .DATA_W      (DATA_W),
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .be    (c_be),
    .waddr (c_addr[AW+1:2]),
    .wdata (c_wdata),
    .raddr (c_addr[AW+1:2]),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      count     <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      lat_we    <= lat_we_next;
      lat_addr  <= lat_addr_next;
      lat_wdata <= lat_wdata_next;
      lat_be    <= lat_be_next;
      rdata_q   <= rdata_next;
      err_q     <= err_next;
    end
  end

  always_comb begin
    state_next     = state;
    count_next     = count;
    lat_we_next    = lat_we;
    lat_addr_next  = lat_addr;
    lat_wdata_next = lat_wdata;
    lat_be_next    = lat_be;
    rdata_next     = rdata_q;
    err_next       = err_q;
    commit         = 1'b0;

    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          lat_we_next    = bus.req_we;
          lat_addr_next  = bus.req_addr;
          lat_wdata_next = bus.req_wdata;
          lat_be_next    = bus.req_be;
          if (LATENCY == 0) begin
            commit     = 1'b1;
            state_next = RESP;
          end else begin
            count_next = LAT_M1;
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (count == 4'd0) begin
          commit     = 1'b1;
          state_next = RESP;
        end else begin
          count_next = count - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rdata_next = '0;
          err_next   = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // Only a clean load returns data; stores and errored requests answer with zero.
    if (commit) begin
      err_next   = c_err;
      rdata_next = (!c_we && !c_err) ? mem_rdata : '0;
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 and a LATENCY=0 instance checked against a transaction-level model.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder_if bus_a ();
  dmem_responder_if bus_b ();

  dmem_responder #(.DATA_W(32), .DEPTH_WORDS(256), .LATENCY(2)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a)
  );
  dmem_responder #(.DATA_W(32), .DEPTH_WORDS(256), .LATENCY(0)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b)
  );

  logic        drv_valid [2];
  logic        drv_we [2];
  logic [31:0] drv_addr [2];
  logic [31:0] drv_wdata [2];
  logic [3:0]  drv_be [2];
  logic        drv_rsp_ready [2];
  logic        obs_req_ready [2];
  logic        obs_rsp_valid [2];
  logic [31:0] obs_rdata [2];
  logic        obs_err [2];

  assign bus_a.req_valid = drv_valid[0];
  assign bus_a.req_we    = drv_we[0];
  assign bus_a.req_addr  = drv_addr[0];
  assign bus_a.req_wdata = drv_wdata[0];
  assign bus_a.req_be    = drv_be[0];
  assign bus_a.rsp_ready = drv_rsp_ready[0];
  assign bus_b.req_valid = drv_valid[1];
  assign bus_b.req_we    = drv_we[1];
  assign bus_b.req_addr  = drv_addr[1];
  assign bus_b.req_wdata = drv_wdata[1];
  assign bus_b.req_be    = drv_be[1];
  assign bus_b.rsp_ready = drv_rsp_ready[1];
  assign obs_req_ready[0] = bus_a.req_ready;
  assign obs_rsp_valid[0] = bus_a.rsp_valid;
  assign obs_rdata[0]     = bus_a.rsp_rdata;
  assign obs_err[0]       = bus_a.rsp_err;
  assign obs_req_ready[1] = bus_b.req_ready;
  assign obs_rsp_valid[1] = bus_b.rsp_valid;
  assign obs_rdata[1]     = bus_b.rsp_rdata;
  assign obs_err[1]       = bus_b.rsp_err;

  // Model state: memory image, one outstanding transaction and its due cycle per instance.
  int          lat [2] = '{2, 0};
  logic [31:0] mm [2][256];
  bit          mk [2][256];
  bit          busy [2];
  int          due [2];
  logic [31:0] exp_rd [2];
  bit          rd_known [2];
  logic        exp_err [2];
  bit          st_pend [2];
  logic [7:0]  st_idx [2];
  logic [31:0] st_data [2];
  logic [3:0]  st_be [2];
  int          accept_cyc [2][$];
  int          rspv_cyc [2][$];

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s actual=%h expected=%h at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst) begin
        busy[d]    = 1'b0;
        st_pend[d] = 1'b0;
        check_output("rst_req_ready", 32'(obs_req_ready[d]), 32'd1);
        check_output("rst_rsp_valid", 32'(obs_rsp_valid[d]), 32'd0);
        check_output("rst_rdata", obs_rdata[d], 32'd0);
        check_output("rst_err", 32'(obs_err[d]), 32'd0);
      end else begin
        bit exp_v;
        exp_v = busy[d] && (cyc >= due[d]);
        if (exp_v && st_pend[d]) begin
          for (int b = 0; b < 4; b++)
            if (st_be[d][b]) mm[d][st_idx[d]][8*b +: 8] = st_data[d][8*b +: 8];
          if (st_be[d] == 4'hF) mk[d][st_idx[d]] = 1'b1;
          st_pend[d] = 1'b0;
        end
        if (exp_v && cyc == due[d]) rspv_cyc[d].push_back(cyc);
        check_output("m_req_ready", 32'(obs_req_ready[d]), 32'(!busy[d]));
        check_output("m_rsp_valid", 32'(obs_rsp_valid[d]), 32'(exp_v));
        check_output("m_rsp_err", 32'(obs_err[d]), exp_v ? 32'(exp_err[d]) : 32'd0);
        if (!exp_v) check_output("m_rdata_idle", obs_rdata[d], 32'd0);
        else if (rd_known[d]) check_output("m_rdata", obs_rdata[d], exp_rd[d]);
        if (exp_v) begin
          if (drv_rsp_ready[d]) busy[d] = 1'b0;
        end else if (!busy[d] && drv_valid[d]) begin
          logic [31:0] a;
          a = drv_addr[d];
          accept_cyc[d].push_back(cyc);
          busy[d]    = 1'b1;
          due[d]     = cyc + lat[d] + 1;
          exp_err[d] = (a % 4 != 0) || (a / 4 >= 256);
          if (drv_we[d]) begin
            exp_rd[d]   = 32'd0;
            rd_known[d] = 1'b1;
            if (!exp_err[d]) begin
              st_pend[d] = 1'b1;
              st_idx[d]  = 8'(a / 4);
              st_data[d] = drv_wdata[d];
              st_be[d]   = drv_be[d];
            end
          end else if (exp_err[d]) begin
            exp_rd[d]   = 32'd0;
            rd_known[d] = 1'b1;
          end else begin
            exp_rd[d]   = mm[d][8'(a / 4)];
            rd_known[d] = mk[d][8'(a / 4)];
          end
        end
      end
    end
  end

  // One full transaction with rsp_ready high; returns the response the DUT gave.
  task automatic apply_stimulus(input int d, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be,
                                output logic [31:0] rdata, output logic err);
    bit ok;
    rdata = 32'hX;
    err   = 1'bX;
    drv_we[d] = we; drv_addr[d] = addr; drv_wdata[d] = wdata; drv_be[d] = be;
    drv_valid[d] = 1'b1;
    drv_rsp_ready[d] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (obs_req_ready[d]) begin ok = 1'b1; break; end
    end
    if (!ok) check_output("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    drv_valid[d] = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (obs_rsp_valid[d]) begin ok = 1'b1; rdata = obs_rdata[d]; err = obs_err[d]; break; end
    end
    if (!ok) check_output("rsp_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] held_rd, la [4];
    bit          ok;
    for (int d = 0; d < 2; d++) begin
      drv_valid[d] = 1'b0; drv_we[d] = 1'b0; drv_addr[d] = '0;
      drv_wdata[d] = '0; drv_be[d] = '0; drv_rsp_ready[d] = 1'b1;
      busy[d] = 1'b0; st_pend[d] = 1'b0;
      for (int w = 0; w < 256; w++) mk[d][w] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    apply_stimulus(0, 1'b1, 32'h0, 32'h11111111, 4'hF, rd, er);
    apply_stimulus(0, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, rd, er);

    $display("[TB] store then load 0x10");
    apply_stimulus(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er);
    check_output("t1_store_rdata", rd, 32'd0);
    check_output("t1_store_lat", 32'(rspv_cyc[0][$] - accept_cyc[0][$]), 32'd3);
    apply_stimulus(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er);
    check_output("t1_load_rdata", rd, 32'hDEADBEEF);
    check_output("t1_load_err", 32'(er), 32'd0);
    check_output("t1_load_lat", 32'(rspv_cyc[0][$] - accept_cyc[0][$]), 32'd3);

    $display("[TB] byte-masked store");
    apply_stimulus(0, 1'b1, 32'h10, 32'h000000AA, 4'h1, rd, er);
    apply_stimulus(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er);
    check_output("t2_rdata", rd, 32'hDEADBEAA);

    $display("[TB] misaligned and out-of-range");
    apply_stimulus(0, 1'b0, 32'h13, 32'h0, 4'h0, rd, er);
    check_output("t3_mis_err", 32'(er), 32'd1);
    check_output("t3_mis_rdata", rd, 32'd0);
    apply_stimulus(0, 1'b0, 32'h400, 32'h0, 4'h0, rd, er);
    check_output("t3_oor_err", 32'(er), 32'd1);
    check_output("t3_oor_rdata", rd, 32'd0);
    apply_stimulus(0, 1'b1, 32'h400, 32'hDDDDDDDD, 4'hF, rd, er);
    check_output("t3_oor_store_err", 32'(er), 32'd1);
    apply_stimulus(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, er);
    check_output("t3_word0_kept", rd, 32'h11111111);
    apply_stimulus(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er);
    check_output("t3_word4_kept", rd, 32'hDEADBEAA);

    $display("[TB] response backpressure");
    drv_rsp_ready[0] = 1'b0;
    drv_we[0] = 1'b0; drv_addr[0] = 32'h10; drv_valid[0] = 1'b1;
    @(posedge clk); #1;
    drv_valid[0] = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (obs_rsp_valid[0]) begin ok = 1'b1; break; end
    end
    if (!ok) check_output("t4_rsp_timeout", 32'd0, 32'd1);
    held_rd = obs_rdata[0];
    check_output("t4_held_first", held_rd, 32'hDEADBEAA);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output("t4_hold_valid", 32'(obs_rsp_valid[0]), 32'd1);
      check_output("t4_hold_rdata", obs_rdata[0], 32'hDEADBEAA);
      check_output("t4_hold_err", 32'(obs_err[0]), 32'd0);
      check_output("t4_hold_ready", 32'(obs_req_ready[0]), 32'd0);
    end
    @(posedge clk); #1;
    drv_rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    check_output("t4_idle_ready", 32'(obs_req_ready[0]), 32'd1);
    check_output("t4_idle_valid", 32'(obs_rsp_valid[0]), 32'd0);
    check_output("t4_idle_rdata", obs_rdata[0], 32'd0);

    $display("[TB] reset during WAIT of a store");
    drv_we[0] = 1'b1; drv_addr[0] = 32'h20; drv_wdata[0] = 32'h12345678;
    drv_be[0] = 4'hF; drv_valid[0] = 1'b1;
    @(posedge clk); #1;
    drv_valid[0] = 1'b0;
    @(posedge clk); #1;
    check_output("t5_in_wait", 32'(obs_req_ready[0]), 32'd0);
    rst = 1'b0;
    #1;
    check_output("t5_rst_ready", 32'(obs_req_ready[0]), 32'd1);
    check_output("t5_rst_valid", 32'(obs_rsp_valid[0]), 32'd0);
    check_output("t5_rst_rdata", obs_rdata[0], 32'd0);
    check_output("t5_rst_err", 32'(obs_err[0]), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    apply_stimulus(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er);
    check_output("t5_load_old", rd, 32'hCAFEF00D);

    $display("[TB] zero latency, req_valid held high");
    la = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};
    for (int k = 0; k < 4; k++) apply_stimulus(1, 1'b1, 32'(4 * k), la[k], 4'hF, rd, er);
    accept_cyc[1].delete();
    rspv_cyc[1].delete();
    drv_rsp_ready[1] = 1'b1;
    drv_we[1] = 1'b0;
    drv_valid[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drv_addr[1] = 32'(4 * k);
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (obs_req_ready[1]) begin ok = 1'b1; break; end
      end
      if (!ok) check_output("t6_accept_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
    end
    drv_valid[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("t6_accepts", 32'(accept_cyc[1].size()), 32'd4);
    check_output("t6_rsps", 32'(rspv_cyc[1].size()), 32'd4);
    if (accept_cyc[1].size() == 4 && rspv_cyc[1].size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        check_output("t6_lat", 32'(rspv_cyc[1][k] - accept_cyc[1][k]), 32'd1);
        if (k > 0) check_output("t6_spacing", 32'(accept_cyc[1][k] - accept_cyc[1][k-1]), 32'd2);
      end
    end
    apply_stimulus(1, 1'b0, 32'hC, 32'h0, 4'h0, rd, er);
    check_output("t6_load_last", rd, 32'hD3D3D3D3);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
